uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one uart_tx instance between NREQ byte requesters.
- Accepts one byte per grant over a valid/ready handshake and issues a single-cycle tx_start with the byte on tx_din.
- Holds the grant until uart_tx reports tx_done_tick, then selects the next requester.
- Sits between the byte sources and the uart_tx / uart_tx_out_buffer chain in top-level integrations.

Parameters:
- NREQ, 4: number of requesters. Legal range is 2..16.
- DBIT, 8: data bits per byte. Must match uart_tx DBIT.
- TIMEOUT_CYCLES, 20000: BUSY watchdog limit in clk cycles. Used only with the optional feature.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  NREQ  bit i = requester i has a byte pending.
- req_data  input  NREQ*DBIT  requester i byte at bits [i*DBIT +: DBIT].
- req_ready  output  NREQ  one-hot; bit i = byte of requester i accepted this cycle.
- tx_start  output  1  one-cycle start pulse to uart_tx.
- tx_din  output  DBIT  byte to uart_tx; registered and held stable from START until the next accept.
- tx_done_tick  input  1  completion tick from uart_tx.
- busy  output  1  high in START and BUSY states.
- grant_id  output  $clog2(NREQ)  index of the current or last granted requester.
- sent_tick  output  1  one-cycle pulse when the granted byte completes.
- timeout_err  output  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Reset: synchronous, active-low. While rst_n=0 at a clock edge:
  - state=IDLE; tx_start=0, tx_din=0, busy=0, sent_tick=0, timeout_err=0; req_ready=0.
  - grant_id=0; internal RR pointer last=NREQ-1, so requester 0 has first priority.
  - A reset in START or BUSY abandons the transfer; no sent_tick is issued.
- IDLE:
  - req_ready is combinational, asserted only in IDLE.
  - Winner = first i with req_valid[i]=1, scanning last+1, last+2, ... modulo NREQ.
  - req_ready[winner]=1 in that same cycle (transfer = valid & ready).
  - On the edge: tx_din <= req_data[winner]; grant_id <= winner; last <= winner; state <= START.
  - No valid request: stay in IDLE with req_ready=0.
- START: lasts exactly one cycle with tx_start=1 and busy=1; then state <= BUSY.
- BUSY:
  - busy=1; wait for tx_done_tick=1.
  - On tx_done_tick: sent_tick=1 in the following cycle, state <= IDLE.
  - The next grant may be taken in that same following IDLE cycle.
- Latency:
  - Accept in cycle N -> tx_start in cycle N+1 -> BUSY from cycle N+2.
  - tx_done_tick in cycle M -> IDLE, sent_tick and a possible new accept all in cycle M+1.
- Boundary conditions:
  - tx_done_tick seen in IDLE or START is ignored; no sent_tick.
  - req_valid changes outside IDLE are ignored; the requester keeps its data until it sees ready.
  - A single active requester is re-granted every cycle it is valid in IDLE (the pointer wraps to itself).
  - All requesters valid: order is strict rotation, e.g. 0,1,2,3,0 for NREQ=4.
  - At most one req_ready bit is set at any time; tx_start never asserts outside START.

Optional Feature:
- Macro: UART_TX_ARBITER_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entering BUSY and increments each BUSY cycle.
  - If the counter reaches TIMEOUT_CYCLES-1 without tx_done_tick: state <= IDLE, timeout_err pulses 1 cycle, no sent_tick.
  - If tx_done_tick arrives in the same cycle as expiry, tx_done_tick wins: sent_tick only.
- Undefined: no counter is built, timeout_err is tied 0, and BUSY waits indefinitely.

Test Plan:
- Reset: rst_n=0 for 3 cycles with all req_valid=1 -> all outputs 0, req_ready=0. After release, first grant_id=0.
- Single byte: req_valid=4'b0100, data2=8'hA5 -> req_ready=4'b0100 same cycle; next cycle tx_start=1, tx_din=8'hA5. tx_done_tick 50 cycles later -> sent_tick next cycle, busy=0.
- Rotation: all four valid, each data=index, done tick 10 cycles after each start -> grant order 0,1,2,3,0 with tx_din=0,1,2,3,0.
- Spurious tick / reset abort: tx_done_tick in IDLE -> no sent_tick. Reset asserted mid-BUSY -> IDLE, no sent_tick, next grant goes to requester 0.
- Back-to-back: requester 1 held valid; done tick in cycle M -> req_ready[1] in M+1 and tx_start in M+2.
- Timeout (macro defined, TIMEOUT_CYCLES=16): no done tick -> timeout_err pulse 16 cycles after BUSY entry, then IDLE. Macro undefined -> busy remains 1 and timeout_err stays 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx between NREQ byte requesters.
// Optional BUSY watchdog enabled by defining UART_TX_ARBITER_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned DBIT           = 8,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DBIT-1:0]      req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      tx_start,
  output logic [DBIT-1:0]           tx_din,
  input  logic                      tx_done_tick,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      sent_tick,
  output logic                      timeout_err
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("uart_tx_arbiter: illegal NREQ or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   last;
  logic [IW-1:0]   win;
  logic [IW-1:0]   cand;
  logic            found;
  logic            accept_c;
  logic            done_c;
  logic            expire_c;

  // Scan last+1, last+2, ... modulo NREQ for the first pending requester.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IW'((32'(last) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign accept_c  = (state == IDLE) && found;
  assign req_ready = (rst_n && accept_c) ? (NREQ'(1) << win) : '0;
  assign done_c    = (state == BUSY) && tx_done_tick;

`ifdef UART_TX_ARBITER_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt;

  // Cycles spent in BUSY; cleared while in START so it reads 0 on BUSY entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == START) begin
      cnt <= '0;
    end else if (state == BUSY) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire_c = (state == BUSY) && (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign expire_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = START;
      START:   state_nxt = BUSY;
      BUSY:    if (done_c || expire_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs and grant bookkeeping; a completion tick beats a watchdog expiry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last        <= IW'(NREQ - 1);
      grant_id    <= '0;
      tx_din      <= '0;
      tx_start    <= 1'b0;
      busy        <= 1'b0;
      sent_tick   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      tx_start    <= (state_nxt == START);
      busy        <= (state_nxt != IDLE);
      sent_tick   <= done_c;
      timeout_err <= expire_c && !done_c;
      if (accept_c) begin
        tx_din   <= req_data[32'(win) * DBIT +: DBIT];
        grant_id <= win;
        last     <= win;
      end
    end
  end

endmodule
